// File: rtl/cache_controller.sv
`default_nettype none
// ==========================================================================
// cache_controller: sequencing FSM for the direct-mapped cache datapath
// Revision: 1.0
// ==========================================================================
module cache_controller #(
   parameter int READ_ONLY = 0,
   parameter int LINE_SIZE = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [1:0] req_operation,
   output logic       req_fulfilled,
   output logic       req_error,
   output logic       hmem_req_valid,
   output logic       hmem_req_store,
   input  logic       hmem_req_fulfilled,
   input  logic       valid_block_match,
   input  logic       valid_dirty_bit,
   input  logic       counter_done,
   output logic       miss_recovery_mode,
   output logic       clear_selected_dirty_bit,
   output logic       set_selected_dirty_bit,
   output logic       perform_write,
   output logic       clear_selected_valid_bit,
   output logic       finish_new_line_install,
   output logic       set_hmem_block_address,
   output logic       use_victim_tag_for_hmem_block_address,
   output logic       reset_counter,
   output logic       decrement_counter,
   output logic       busy
);

   localparam logic [3:0] S_IDLE      = 4'b0001;
   localparam logic [3:0] S_LOOKUP    = 4'b0010;
   localparam logic [3:0] S_WRITEBACK = 4'b0100;
   localparam logic [3:0] S_FETCH     = 4'b1000;

   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_STORE   = 2'b01;
   localparam logic [1:0] OP_CLFLUSH = 2'b10;

   if ((LINE_SIZE < 4) || ((LINE_SIZE % 4) != 0)) begin : g_bad_line_size
      $error("cache_controller: LINE_SIZE must be a positive multiple of 4");
   end

   logic [3:0] state_q, state_d;
   logic       flush_q, flush_d;
   logic       w_read_only;
   logic       w_illegal;
   logic       w_dirty_victim;

   assign w_read_only    = (READ_ONLY != 0);
   assign w_illegal      = (req_operation == 2'b11) ||
                           (w_read_only && (req_operation != OP_LOAD));
   // An instruction cache never holds dirty lines, so the flag is ignored.
   assign w_dirty_victim = valid_dirty_bit && !w_read_only;

   always_comb begin
      state_d                               = state_q;
      flush_d                               = flush_q;
      req_fulfilled                         = 1'b0;
      req_error                             = 1'b0;
      hmem_req_valid                        = 1'b0;
      hmem_req_store                        = 1'b0;
      miss_recovery_mode                    = 1'b0;
      clear_selected_dirty_bit              = 1'b0;
      set_selected_dirty_bit                = 1'b0;
      perform_write                         = 1'b0;
      clear_selected_valid_bit              = 1'b0;
      finish_new_line_install               = 1'b0;
      set_hmem_block_address                = 1'b0;
      use_victim_tag_for_hmem_block_address = 1'b0;
      reset_counter                         = 1'b0;
      decrement_counter                     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (w_illegal) begin
               req_error     = 1'b1;
               req_fulfilled = 1'b1;
               state_d       = S_IDLE;
            end else if (req_operation == OP_CLFLUSH) begin
               if (!valid_block_match) begin
                  req_fulfilled = 1'b1;
                  state_d       = S_IDLE;
               end else if (w_dirty_victim) begin
                  set_hmem_block_address                = 1'b1;
                  use_victim_tag_for_hmem_block_address = 1'b1;
                  reset_counter                         = 1'b1;
                  flush_d                               = 1'b1;
                  state_d                               = S_WRITEBACK;
               end else begin
                  clear_selected_valid_bit = 1'b1;
                  req_fulfilled            = 1'b1;
                  state_d                  = S_IDLE;
               end
            end else if (valid_block_match) begin
               req_fulfilled = 1'b1;
               if (req_operation == OP_STORE) begin
                  perform_write          = 1'b1;
                  set_selected_dirty_bit = 1'b1;
               end
               state_d = S_IDLE;
            end else if (w_dirty_victim) begin
               set_hmem_block_address                = 1'b1;
               use_victim_tag_for_hmem_block_address = 1'b1;
               reset_counter                         = 1'b1;
               flush_d                               = 1'b0;
               state_d                               = S_WRITEBACK;
            end else begin
               set_hmem_block_address = 1'b1;
               reset_counter          = 1'b1;
               state_d                = S_FETCH;
            end
         end
         S_WRITEBACK: begin
            miss_recovery_mode = 1'b1;
            hmem_req_valid     = 1'b1;
            hmem_req_store     = 1'b1;
            if (hmem_req_fulfilled) begin
               if (!counter_done) begin
                  decrement_counter = 1'b1;
               end else begin
                  clear_selected_dirty_bit = 1'b1;
                  if (flush_q) begin
                     clear_selected_valid_bit = 1'b1;
                     req_fulfilled            = 1'b1;
                     state_d                  = S_IDLE;
                  end else begin
                     set_hmem_block_address = 1'b1;
                     reset_counter          = 1'b1;
                     state_d                = S_FETCH;
                  end
               end
            end
         end
         S_FETCH: begin
            miss_recovery_mode = 1'b1;
            hmem_req_valid     = 1'b1;
            if (hmem_req_fulfilled) begin
               perform_write = 1'b1;
               if (!counter_done) begin
                  decrement_counter = 1'b1;
               end else begin
                  // Replay the lookup so the access completes through the hit path.
                  finish_new_line_install = 1'b1;
                  state_d                 = S_LOOKUP;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// Bench for cache_controller: datapath + higher-memory models, transaction-level
// reference for latency, strobe counts and line metadata.
module tb_cache_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       req_valid;
   logic [1:0] req_operation;
   logic       hmem_req_fulfilled;
   logic       valid_block_match, valid_dirty_bit, counter_done;
   logic       req_fulfilled, req_error, hmem_req_valid, hmem_req_store;
   logic       miss_recovery_mode, clear_selected_dirty_bit, set_selected_dirty_bit;
   logic       perform_write, clear_selected_valid_bit, finish_new_line_install;
   logic       set_hmem_block_address, use_victim_tag_for_hmem_block_address;
   logic       reset_counter, decrement_counter, busy;

   logic       ro_req_valid;
   logic [1:0] ro_req_op;
   logic       ro_match, ro_dirty, ro_done, ro_hful;
   logic       ro_ful, ro_err, ro_hv, ro_hs, ro_miss, ro_cd, ro_sd, ro_pw, ro_cv;
   logic       ro_fin, ro_sha, ro_vic, ro_rc, ro_dec, ro_busy;

   cache_controller #(.READ_ONLY(0), .LINE_SIZE(32)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_operation(req_operation),
      .req_fulfilled(req_fulfilled), .req_error(req_error),
      .hmem_req_valid(hmem_req_valid), .hmem_req_store(hmem_req_store),
      .hmem_req_fulfilled(hmem_req_fulfilled), .valid_block_match(valid_block_match),
      .valid_dirty_bit(valid_dirty_bit), .counter_done(counter_done),
      .miss_recovery_mode(miss_recovery_mode), .clear_selected_dirty_bit(clear_selected_dirty_bit),
      .set_selected_dirty_bit(set_selected_dirty_bit), .perform_write(perform_write),
      .clear_selected_valid_bit(clear_selected_valid_bit),
      .finish_new_line_install(finish_new_line_install),
      .set_hmem_block_address(set_hmem_block_address),
      .use_victim_tag_for_hmem_block_address(use_victim_tag_for_hmem_block_address),
      .reset_counter(reset_counter), .decrement_counter(decrement_counter), .busy(busy)
   );

   cache_controller #(.READ_ONLY(1), .LINE_SIZE(32)) dut_ro (
      .clk(clk), .reset_n(reset_n), .req_valid(ro_req_valid), .req_operation(ro_req_op),
      .req_fulfilled(ro_ful), .req_error(ro_err),
      .hmem_req_valid(ro_hv), .hmem_req_store(ro_hs),
      .hmem_req_fulfilled(ro_hful), .valid_block_match(ro_match),
      .valid_dirty_bit(ro_dirty), .counter_done(ro_done),
      .miss_recovery_mode(ro_miss), .clear_selected_dirty_bit(ro_cd),
      .set_selected_dirty_bit(ro_sd), .perform_write(ro_pw),
      .clear_selected_valid_bit(ro_cv), .finish_new_line_install(ro_fin),
      .set_hmem_block_address(ro_sha), .use_victim_tag_for_hmem_block_address(ro_vic),
      .reset_counter(ro_rc), .decrement_counter(ro_dec), .busy(ro_busy)
   );

   wire [14:0] outs = {req_fulfilled, req_error, hmem_req_valid, hmem_req_store,
                       miss_recovery_mode, clear_selected_dirty_bit, set_selected_dirty_bit,
                       perform_write, clear_selected_valid_bit, finish_new_line_install,
                       set_hmem_block_address, use_victim_tag_for_hmem_block_address,
                       reset_counter, decrement_counter, busy};
   wire [14:0] ro_outs = {ro_ful, ro_err, ro_hv, ro_hs, ro_miss, ro_cd, ro_sd, ro_pw, ro_cv,
                          ro_fin, ro_sha, ro_vic, ro_rc, ro_dec, ro_busy};

   // Datapath model: 4 lines, 8-word counter, driven by the controller strobes.
   logic       dp_clear;
   logic [1:0] cur_idx, cur_tag;
   logic       dp_v [4];
   logic       dp_d [4];
   logic [1:0] dp_tag [4];
   logic [2:0] dp_cnt;

   assign valid_block_match = dp_v[cur_idx] && (dp_tag[cur_idx] == cur_tag);
   assign valid_dirty_bit   = dp_v[cur_idx] && dp_d[cur_idx];
   assign counter_done      = (dp_cnt == 3'd0);

   always @(posedge clk) begin
      if (dp_clear) begin
         for (int i = 0; i < 4; i++) begin
            dp_v[i]   <= 1'b0;
            dp_d[i]   <= 1'b0;
            dp_tag[i] <= 2'd0;
         end
         dp_cnt <= 3'd0;
      end else begin
         if (reset_counter) dp_cnt <= 3'd7;
         else if (decrement_counter) dp_cnt <= dp_cnt - 3'd1;
         if (set_selected_dirty_bit)   dp_d[cur_idx] <= 1'b1;
         if (clear_selected_dirty_bit) dp_d[cur_idx] <= 1'b0;
         if (clear_selected_valid_bit) dp_v[cur_idx] <= 1'b0;
         if (finish_new_line_install) begin
            dp_v[cur_idx]   <= 1'b1;
            dp_tag[cur_idx] <= cur_tag;
            dp_d[cur_idx]   <= 1'b0;
         end
      end
   end

   // Higher memory: completes each word 2 cycles after it is requested.
   logic hm_cnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hm_cnt             <= 1'b0;
         hmem_req_fulfilled <= 1'b0;
      end else if (hmem_req_fulfilled) begin
         hmem_req_fulfilled <= 1'b0;
         hm_cnt             <= 1'b0;
      end else if (hmem_req_valid) begin
         if (hm_cnt) hmem_req_fulfilled <= 1'b1;
         else        hm_cnt             <= 1'b1;
      end else begin
         hm_cnt <= 1'b0;
      end
   end

   a_req_held: assert property (@(posedge clk) disable iff (!reset_n) busy |-> req_valid)
      else $error("FAIL req_valid_held: req_valid=0 required 1 while busy");

   typedef struct packed {
      logic [7:0] lat, hv, wb, fe, wr, dec, fin, cd, cv, sd, err, v1, v0;
   } tc_t;

   int n_cmp = 0;
   int n_fail = 0;

   logic       ref_v [4];
   logic       ref_d [4];
   logic [1:0] ref_tag [4];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Transaction-level expectations derived from the hit/miss/dirty rules.
   function automatic tc_t predict(input logic [1:0] op, input bit hit, input bit dirty);
      tc_t e;
      e = '0;
      e.lat = 8'd2;
      if (op == 2'd3) begin
         e.err = 8'd1;
      end else if (op == 2'd2) begin
         if (hit) begin
            e.cv = 8'd1;
            if (dirty) begin
               e.wb = 8'd8; e.dec = 8'd7; e.cd = 8'd1; e.v1 = 8'd1;
               e.hv = 8'd24; e.lat = 8'd26;
            end
         end
      end else if (hit) begin
         if (op == 2'd1) begin e.wr = 8'd1; e.sd = 8'd1; end
      end else begin
         e.fe = 8'd8; e.dec = 8'd7; e.fin = 8'd1; e.v0 = 8'd1;
         e.hv = 8'd24; e.lat = 8'd27;
         e.wr = (op == 2'd1) ? 8'd9 : 8'd8;
         e.sd = (op == 2'd1) ? 8'd1 : 8'd0;
         if (dirty) begin
            e.wb = 8'd8; e.dec = 8'd14; e.cd = 8'd1; e.v1 = 8'd1;
            e.hv = 8'd48; e.lat = 8'd51;
         end
      end
      return e;
   endfunction

   task automatic accumulate(inout tc_t g);
      g.hv  = g.hv  + {7'd0, hmem_req_valid};
      g.wb  = g.wb  + {7'd0, hmem_req_valid & hmem_req_fulfilled & hmem_req_store};
      g.fe  = g.fe  + {7'd0, hmem_req_valid & hmem_req_fulfilled & ~hmem_req_store};
      g.wr  = g.wr  + {7'd0, perform_write};
      g.dec = g.dec + {7'd0, decrement_counter};
      g.fin = g.fin + {7'd0, finish_new_line_install};
      g.cd  = g.cd  + {7'd0, clear_selected_dirty_bit};
      g.cv  = g.cv  + {7'd0, clear_selected_valid_bit};
      g.sd  = g.sd  + {7'd0, set_selected_dirty_bit};
      g.err = g.err + {7'd0, req_error};
      g.v1  = g.v1  + {7'd0, set_hmem_block_address & use_victim_tag_for_hmem_block_address};
      g.v0  = g.v0  + {7'd0, set_hmem_block_address & ~use_victim_tag_for_hmem_block_address};
   endtask

   // Called just after a rising edge; returns just after a rising edge with req_valid low.
   task automatic run_req(input logic [1:0] op, input logic [1:0] idx, input logic [1:0] tag,
                          input string name);
      tc_t exp, got;
      bit  hit, dirty;
      int  cyc;
      hit   = ref_v[idx] && (ref_tag[idx] == tag);
      dirty = ref_v[idx] && ref_d[idx];
      exp   = predict(op, hit, dirty);
      got   = '0;
      cur_idx = idx; cur_tag = tag; req_operation = op; req_valid = 1'b1;
      cyc = 1;
      while (cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         accumulate(got);
         if (req_fulfilled) break;
      end
      got.lat = 8'(cyc);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({name, "_counts"}, {24'd0, got}, {24'd0, exp});
      if (op == 2'd2) begin
         if (hit) begin ref_v[idx] = 1'b0; ref_d[idx] = 1'b0; end
      end else if (op != 2'd3) begin
         if (!hit) begin ref_v[idx] = 1'b1; ref_tag[idx] = tag; ref_d[idx] = 1'b0; end
         if (op == 2'd1) ref_d[idx] = 1'b1;
      end
      check({name, "_meta"}, {124'd0, dp_v[idx], dp_d[idx], dp_tag[idx]},
            {124'd0, ref_v[idx], ref_d[idx], ref_tag[idx]});
   endtask

   task automatic ro_req(input logic [1:0] op, input string name);
      ro_req_op = op; ro_req_valid = 1'b1;
      @(posedge clk); #1;
      check(name, {113'd0, ro_outs}, {113'd0, 15'b110000000000001});
      @(posedge clk); #1;
      ro_req_valid = 1'b0;
      check({name, "_idle"}, {113'd0, ro_outs}, 128'd0);
   endtask

   initial begin
      tc_t g;
      int  cyc, r;
      logic [1:0] op, idx, tag;

      reset_n = 1'b0; dp_clear = 1'b1;
      req_valid = 1'b0; req_operation = 2'd0; cur_idx = 2'd0; cur_tag = 2'd0;
      ro_req_valid = 1'b0; ro_req_op = 2'd0;
      ro_match = 1'b0; ro_dirty = 1'b1; ro_done = 1'b0; ro_hful = 1'b0;
      for (int i = 0; i < 4; i++) begin ref_v[i] = 1'b0; ref_d[i] = 1'b0; ref_tag[i] = 2'd0; end
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {113'd0, outs}, 128'd0);
      reset_n = 1'b1; dp_clear = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", {113'd0, outs}, 128'd0);

      run_req(2'd0, 2'd0, 2'd1, "load_clean_miss");
      run_req(2'd0, 2'd0, 2'd1, "load_hit");
      run_req(2'd1, 2'd0, 2'd1, "store_hit");
      run_req(2'd0, 2'd0, 2'd1, "load_hit_b2b");
      run_req(2'd1, 2'd0, 2'd2, "store_dirty_miss");
      run_req(2'd2, 2'd0, 2'd2, "flush_hit_dirty");
      run_req(2'd2, 2'd0, 2'd2, "flush_miss");
      run_req(2'd0, 2'd1, 2'd0, "load_miss_idx1");
      run_req(2'd2, 2'd1, 2'd0, "flush_hit_clean");
      run_req(2'd3, 2'd1, 2'd0, "reserved_op");

      ro_req(2'd1, "ro_store");
      ro_req(2'd2, "ro_clflush");
      ro_req(2'd3, "ro_reserved");
      // Dirty flag is high, yet the instruction cache must go straight to a fetch.
      ro_req_op = 2'd0; ro_req_valid = 1'b1;
      @(posedge clk); #1;
      check("ro_load_lookup", {113'd0, ro_outs}, {113'd0, 15'b000000000010101});
      @(posedge clk); #1;
      check("ro_load_fetch", {113'd0, ro_outs}, {113'd0, 15'b001010000000001});

      for (int n = 0; n < 40; n++) begin
         r   = int'($urandom_range(0, 9));
         op  = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         idx = 2'($urandom_range(0, 3));
         tag = 2'($urandom_range(0, 1));
         run_req(op, idx, tag, "rand");
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      run_req(2'd2, 2'd2, 2'd0, "flush_before_reset");
      run_req(2'd2, 2'd2, 2'd1, "flush_before_reset2");
      cur_idx = 2'd2; cur_tag = 2'd3; req_operation = 2'd0; req_valid = 1'b1;
      g = '0; cyc = 0;
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         accumulate(g);
         if (g.fe == 8'd3 && hmem_req_valid && !hmem_req_fulfilled) break;
      end
      check("reset_point_reached", {96'd0, 32'(g.fe), 32'(hmem_req_valid)}, {96'd0, 32'd3, 32'd1});
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_outs", {113'd0, outs}, 128'd0);
      check("async_reset_ro_outs", {113'd0, ro_outs}, 128'd0);
      req_valid = 1'b0; ro_req_valid = 1'b0;
      @(posedge clk); #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_async_reset", {113'd0, outs}, 128'd0);
      check("meta_untouched_by_reset", {126'd0, dp_v[2], dp_d[2]}, 128'd0);
      run_req(2'd0, 2'd2, 2'd3, "load_after_reset");
      run_req(2'd0, 2'd2, 2'd3, "hit_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Sequencing FSM for the direct-mapped cache datapath. It drives all datapath control strobes (miss_recovery_mode, counter control, metadata set/clear, write enable, higher-memory block-address latch) from the requester handshake and the datapath status flags (valid_block_match, valid_dirty_bit, counter_done). It runs hits, clean-miss line fills, dirty-victim writeback followed by fill, and single-line flush (CLFLUSH). One instance sits beside each cache_datapath instance, with matching READ_ONLY.

Parameters:
READ_ONLY, 0, 1 = instruction cache: no writeback path, no dirty handling; STORE/CLFLUSH raise req_error.
LINE_SIZE, 32, bytes per line; informational only, since word count is tracked by the datapath counter.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request pending; requester holds it and address/data/operation stable until req_fulfilled
req_operation  in  2  00 LOAD, 01 STORE, 10 CLFLUSH, 11 reserved
req_fulfilled  out  1  single-cycle completion pulse; load data valid on datapath fetched_word this cycle
req_error  out  1  single-cycle pulse, coincident with req_fulfilled, for illegal op
hmem_req_valid  out  1  higher-memory word request
hmem_req_store  out  1  1 = word writeback, 0 = word fetch; stable while hmem_req_valid
hmem_req_fulfilled  in  1  higher-memory single-cycle word completion
valid_block_match  in  1  datapath: selected line valid and tag equal
valid_dirty_bit  in  1  datapath: selected line valid and dirty
counter_done  in  1  datapath: word counter == 0
miss_recovery_mode, clear_selected_dirty_bit, set_selected_dirty_bit, perform_write, clear_selected_valid_bit, finish_new_line_install, set_hmem_block_address, use_victim_tag_for_hmem_block_address, reset_counter, decrement_counter  out  1 each  datapath strobes
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 immediately, including mid-transfer hmem_req_valid. Datapath metadata is not touched by this block.
- Outputs are Moore/Mealy combinational from state plus inputs; only the state register is sequential.
- IDLE: req_valid=1 -> LOOKUP. No other outputs.
- LOOKUP: one cycle, evaluates the flags.
  - LOAD hit: req_fulfilled=1 -> IDLE.
  - STORE hit: perform_write=1, set_selected_dirty_bit=1, req_fulfilled=1 -> IDLE.
  - CLFLUSH miss: req_fulfilled=1 -> IDLE.
  - CLFLUSH hit clean: clear_selected_valid_bit=1, req_fulfilled=1 -> IDLE.
  - CLFLUSH hit dirty: set_hmem_block_address=1, use_victim_tag_for_hmem_block_address=1, reset_counter=1 -> WRITEBACK (flush flag set).
  - LOAD/STORE miss with valid_dirty_bit=1: same three strobes as CLFLUSH hit dirty -> WRITEBACK (flush flag clear).
  - LOAD/STORE miss clean: set_hmem_block_address=1, use_victim=0, reset_counter=1 -> FETCH.
  - READ_ONLY=1 and op STORE/CLFLUSH, or op==11: req_error=1, req_fulfilled=1 -> IDLE, with no datapath strobes.
  - READ_ONLY=1 forces the valid_dirty_bit path off.
- WRITEBACK: miss_recovery_mode=1, hmem_req_valid=1, hmem_req_store=1.
  - On hmem_req_fulfilled with counter_done=0: decrement_counter=1.
  - On hmem_req_fulfilled with counter_done=1: clear_selected_dirty_bit=1. If flushing: clear_selected_valid_bit=1, req_fulfilled=1 -> IDLE. Otherwise: set_hmem_block_address=1, use_victim=0, reset_counter=1 -> FETCH.
- FETCH: miss_recovery_mode=1, hmem_req_valid=1, hmem_req_store=0.
  - On hmem_req_fulfilled: perform_write=1.
  - If counter_done=0: also decrement_counter=1.
  - If counter_done=1: also finish_new_line_install=1 -> LOOKUP. The replayed access now hits and completes through the hit path.
- Word order: the counter counts down, so words transfer from highest offset to 0. Exactly WORDS_PER_LINE handshakes per transfer.
- hmem_req_valid stays high continuously across words within a transfer. hmem_req_fulfilled outside WRITEBACK/FETCH is ignored.
- Latency:
  - Hit: req_fulfilled in the 2nd cycle of req_valid.
  - Clean miss: 2 + sum of fetch waits + 1 cycles.
  - Back-to-back requests are accepted the cycle after req_fulfilled.
- req_valid dropping before req_fulfilled is illegal; the bench asserts it never occurs.
- Exactly one of IDLE/LOOKUP/WRITEBACK/FETCH is active (onehot, encoded as enum). Unreachable encodings -> IDLE.

Test Plan:
Bench defaults: LINE_SIZE=32 (8 words); hmem model pulses hmem_req_fulfilled 2 cycles after each word request.
- LOAD hit (match=1) -> req_fulfilled at cycle 2; no hmem_req_valid; no perform_write.
- STORE hit -> one cycle with perform_write=set_selected_dirty_bit=req_fulfilled=1; next request accepted the following cycle.
- LOAD clean miss -> 8 fetch handshakes, 8 perform_write pulses, 7 decrement_counter, then finish_new_line_install; model sets match=1; req_fulfilled in the LOOKUP replay.
- STORE miss with dirty victim -> use_victim=1 latch, 8 store handshakes, clear_selected_dirty_bit, then 8 fetches, then a dirty-set write and req_fulfilled.
- CLFLUSH hit dirty -> 8 writebacks, then clear_selected_dirty_bit and clear_selected_valid_bit with req_fulfilled in the same cycle. CLFLUSH miss -> req_fulfilled at cycle 2 only. READ_ONLY=1 STORE -> req_error and req_fulfilled, no strobes.
- reset_n low during the 4th fetch word -> hmem_req_valid and all outputs 0 asynchronously; after release, IDLE and a new LOAD starts cleanly.
